// File: rtl/puf_collect_n.sv
// rtl/puf_collect_n.sv - majority-voting PUF response collector
// Steps the challenge LFSR through NUM_WORDS challenges and packs one voted word per challenge.
module puf_collect_n #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 8,
  parameter int VOTES     = 1,
  parameter int SETTLE    = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WORD_W-1:0]           seed,
  output logic                        lfsr_load,
  output logic                        lfsr_next,
  input  logic                        lfsr_ready,
  output logic [WORD_W-1:0]           lfsr_seed,
  input  logic [WORD_W-1:0]           puf_data,
  output logic [WORD_W*NUM_WORDS-1:0] resp_out,
  output logic                        resp_valid,
  output logic                        err,
  output logic                        busy
);
  localparam int RW = WORD_W * NUM_WORDS;
  localparam int CW = $clog2(VOTES + 1);
  localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int IW = $clog2(NUM_WORDS);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] HALF        = CW'(VOTES / 2);
  localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
  localparam logic [IW-1:0] WORD_LAST   = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] WDOG_LAST   = TW'(TIMEOUT - 1);
  localparam logic [7:0]    SETTLE_LAST = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_SETTLE, S_SAMPLE, S_ADVANCE, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic                      ready_q;
  logic [WORD_W-1:0]         seed_q, seed_d;
  logic [RW-1:0]             resp_q, resp_d;
  logic [WORD_W-1:0][CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]             word_q, word_d;
  logic [VW-1:0]             vote_q, vote_d;
  logic [TW-1:0]             wdog_q, wdog_d;
  logic [7:0]                settle_q, settle_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      load_q, load_d;

  logic                      rdy_edge;
  logic [WORD_W-1:0][CW-1:0] sum_w;
  logic [WORD_W-1:0]         vote_w;

  assign rdy_edge = lfsr_ready & ~ready_q;

  // Running per-bit vote tally including the read taken this cycle.
  always_comb begin
    sum_w  = '0;
    vote_w = '0;
    for (int b = 0; b < WORD_W; b++) begin
      sum_w[b]  = cnt_q[b] + CW'(puf_data[b]);
      vote_w[b] = (sum_w[b] > HALF);
    end
  end

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    resp_d   = resp_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    vote_d   = vote_q;
    wdog_d   = wdog_q;
    settle_d = settle_q;
    valid_d  = valid_q;
    err_d    = err_q;
    load_d   = load_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          seed_d  = seed;
          resp_d  = '0;
          cnt_d   = '0;
          word_d  = '0;
          vote_d  = '0;
          wdog_d  = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
          load_d  = 1'b1;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_edge) begin
          wdog_d   = '0;
          settle_d = '0;
          if (SETTLE > 0) state_d = S_SETTLE;
          else            state_d = S_SAMPLE;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          load_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
        else                         settle_d = settle_q + 8'd1;
      end
      S_SAMPLE: begin
        cnt_d = sum_w;
        if (vote_q == VOTE_LAST) begin
          cnt_d  = '0;
          vote_d = '0;
          for (int w = 0; w < NUM_WORDS; w++) begin
            if (word_q == IW'(w)) resp_d[RW-1-w*WORD_W -: WORD_W] = vote_w;
          end
          if (word_q == WORD_LAST) begin
            load_d  = 1'b0;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            word_d  = word_q + IW'(1);
            state_d = S_ADVANCE;
          end
        end else begin
          vote_d   = vote_q + VW'(1);
          settle_d = '0;
          if (SETTLE > 0) state_d = S_SETTLE;
          else            state_d = S_SAMPLE;
        end
      end
      S_ADVANCE: state_d = S_WAIT_RDY;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      seed_q   <= '0;
      resp_q   <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      vote_q   <= '0;
      wdog_q   <= '0;
      settle_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= lfsr_ready;
      seed_q   <= seed_d;
      resp_q   <= resp_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      vote_q   <= vote_d;
      wdog_q   <= wdog_d;
      settle_q <= settle_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      load_q   <= load_d;
    end
  end

  assign lfsr_load  = load_q;
  assign lfsr_next  = (state_q == S_ADVANCE);
  assign lfsr_seed  = seed_q;
  assign resp_out   = resp_q;
  assign resp_valid = valid_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule

// File: tb/tb_puf_collect_n.sv
// tb/tb_puf_collect_n.sv - bench for puf_collect_n
// Instance A uses defaults; instance B votes 3 reads over 2 words with a 3-cycle settle and short watchdog.
module tb_puf_collect_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_a = 1'b0, load_a, next_a, rdy_a = 1'b0, valid_a, err_a, busy_a;
  logic [15:0]  seed_a = '0, lseed_a, puf_a = '0;
  logic [127:0] resp_a;
  logic         start_b = 1'b0, load_b, next_b, rdy_b = 1'b0, valid_b, err_b, busy_b;
  logic [15:0]  seed_b = '0, lseed_b, puf_b = '0;
  logic [31:0]  resp_b;

  puf_collect_n dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed_a), .lfsr_load(load_a), .lfsr_next(next_a),
    .lfsr_ready(rdy_a), .lfsr_seed(lseed_a), .puf_data(puf_a), .resp_out(resp_a),
    .resp_valid(valid_a), .err(err_a), .busy(busy_a)
  );

  puf_collect_n #(.WORD_W(16), .NUM_WORDS(2), .VOTES(3), .SETTLE(3), .TIMEOUT(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .lfsr_load(load_b), .lfsr_next(next_b),
    .lfsr_ready(rdy_b), .lfsr_seed(lseed_b), .puf_data(puf_b), .resp_out(resp_b),
    .resp_valid(valid_b), .err(err_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] tab_a [8];
  logic [15:0] reads_b [2][3];
  int   chal_a = 0, dly_a = 0, nexts_a = 0;
  logic load_prev_a = 1'b0;
  int   chal_b = 0, dly_b = 0, phase_b = -1;
  logic load_prev_b = 1'b0, hold_b = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock; then the LFSR/PUF models react to what the DUTs show this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (next_a) begin
      nexts_a++; chal_a++; rdy_a = 1'b0; dly_a = 2;
    end else if (load_a && !load_prev_a) begin
      chal_a = 0; rdy_a = 1'b0; dly_a = 2;
    end else if (dly_a > 0) begin
      dly_a--;
      if (dly_a == 0) rdy_a = 1'b1;
    end
    load_prev_a = load_a;
    puf_a = tab_a[chal_a % 8];

    if (phase_b >= 0) phase_b++;
    if (next_b) begin
      chal_b++; rdy_b = 1'b0; dly_b = 2;
    end else if (load_b && !load_prev_b) begin
      chal_b = 0; rdy_b = 1'b0; dly_b = 2;
    end else if (dly_b > 0) begin
      dly_b--;
      if (dly_b == 0 && !hold_b) begin
        rdy_b = 1'b1; phase_b = 0;
      end
    end
    load_prev_b = load_b;
    if (phase_b > 12) phase_b = -1;
    // Valid data only on the exact sampling edges; anything else is noise that must not be captured.
    if (phase_b > 0 && phase_b % 4 == 0) puf_b = reads_b[chal_b % 2][phase_b / 4 - 1];
    else                                 puf_b = 16'($urandom);
  endtask

  task automatic run_a(input logic [15:0] sd, input bit disturb);
    logic [127:0] exp_v;
    int n, n0;
    bit dist_done;
    exp_v = '0;
    for (int k = 0; k < 8; k++) exp_v = {exp_v[111:0], tab_a[k]};
    n0 = nexts_a;
    dist_done = 1'b0;
    seed_a = sd; start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1);
    chk("a_load_after_start", load_a, 1);
    chk("a_valid_cleared", valid_a, 0);
    chk("a_resp_cleared", resp_a, 0);
    n = 0;
    while (!valid_a && !err_a && n < 1000) begin
      if (disturb && !dist_done && chal_a == 3) begin
        start_a = 1'b1; seed_a = ~sd; tick(); start_a = 1'b0;
        dist_done = 1'b1;
        chk("a_seed_held_busy", lseed_a, sd);
      end else begin
        tick();
      end
      n++;
    end
    chk("a_done_in_budget", n < 1000, 1);
    chk("a_resp", resp_a, exp_v);
    chk("a_valid", valid_a, 1);
    chk("a_err", err_a, 0);
    chk("a_load_low_done", load_a, 0);
    chk("a_busy_low_done", busy_a, 0);
    chk("a_next_pulses", nexts_a - n0, 7);
    chk("a_seed", lseed_a, sd);
  endtask

  task automatic run_b();
    logic [31:0] exp_v;
    int n, c;
    exp_v = '0;
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 16; b++) begin
        c = int'(reads_b[w][0][b]) + int'(reads_b[w][1][b]) + int'(reads_b[w][2][b]);
        exp_v[31 - w*16 - (15 - b)] = (c >= 2);
      end
    seed_b = 16'($urandom); start_b = 1'b1; tick(); start_b = 1'b0;
    chk("b_busy_after_start", busy_b, 1);
    chk("b_err_cleared", err_b, 0);
    n = 0;
    while (!valid_b && !err_b && n < 1000) begin
      tick(); n++;
    end
    chk("b_done_in_budget", n < 1000, 1);
    chk("b_resp", resp_b, exp_v);
    chk("b_valid", valid_b, 1);
    chk("b_err", err_b, 0);
  endtask

  initial begin
    int n, n0;
    for (int k = 0; k < 8; k++) tab_a[k] = 16'hA000 + 16'(k);
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_resp", resp_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_load", load_a, 0);
    chk("rst_next", next_a, 0);
    chk("rst_seed", lseed_a, 0);

    run_a(16'hACE1, 1'b0);
    chk("default_resp_const", resp_a, 128'hA000A001A002A003A004A005A006A007);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) tab_a[k] = 16'($urandom);
      run_a(16'($urandom), r == 1);
    end

    seed_a = 16'h1234; start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (chal_a != 4 && n < 1000) begin
      tick(); n++;
    end
    chk("reach_word4", n < 1000, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_resp", resp_a, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_load", load_a, 0);
    chk("midrst_seed", lseed_a, 0);
    n0 = nexts_a;
    repeat (100) tick();
    chk("midrst_no_next", nexts_a - n0, 0);
    chk("midrst_still_idle", busy_a, 0);
    run_a(16'h5A5A, 1'b0);

    reads_b[0][0] = 16'h00FF; reads_b[0][1] = 16'h0F0F; reads_b[0][2] = 16'h3333;
    reads_b[1][0] = 16'h00FF; reads_b[1][1] = 16'h0F0F; reads_b[1][2] = 16'h3333;
    run_b();
    chk("b_majority_const", resp_b, 32'h033F033F);
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 2; w++)
        for (int j = 0; j < 3; j++) reads_b[w][j] = 16'($urandom);
      run_b();
    end

    hold_b = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    repeat (31) tick();
    chk("to_err_early", err_b, 0);
    chk("to_busy_early", busy_b, 1);
    tick();
    chk("to_err", err_b, 1);
    chk("to_busy", busy_b, 0);
    chk("to_valid", valid_b, 0);
    chk("to_load", load_b, 0);
    hold_b = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int j = 0; j < 3; j++) reads_b[w][j] = 16'($urandom);
    run_b();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/puf_collect_n.md
# puf_collect_n

Parametrised PUF response collector: loads a challenge seed into the challenge LFSR, steps it NUM_WORDS times, samples the WORD_W-bit PUF output at each challenge and assembles a NUM_WORDS×WORD_W response. New over the fixed 8×16 collector:
- each challenge is read VOTES times and each bit resolved by majority;
- a programmable settle delay;
- a watchdog timeout with error flag;
- restartable start/busy/valid handshake.

Sits between the challenge LFSR, the PUF array and the key/ID consumer.

## Interface
- WORD_W, 16, PUF word width (also LFSR/seed width)
- NUM_WORDS, 8, words per response (2..64)
- VOTES, 1, reads per challenge; odd, 1..7
- SETTLE, 1, idle cycles between challenge-ready and each sample (0..255)
- TIMEOUT, 1024, max cycles waiting for LFSR ready before error (≥4)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin collection; honoured only when busy=0
- seed  in  WORD_W  challenge seed, captured on accepted start
- lfsr_load  out  1  LFSR load/run enable (start_new equivalent)
- lfsr_next  out  1  one-cycle pulse: advance LFSR
- lfsr_ready  in  1  LFSR challenge valid; only its 0→1 edges are used
- lfsr_seed  out  WORD_W  captured seed, held stable while busy
- puf_data  in  WORD_W  PUF response for current challenge
- resp_out  out  WORD_W*NUM_WORDS  assembled response; word 0 in MSBs
- resp_valid  out  1  level; response complete and error-free
- err  out  1  level; watchdog expired
- busy  out  1  collection in progress

## Operation
- States: IDLE, WAIT_RDY, SETTLE, SAMPLE, ADVANCE, DONE.
- Registered ready_q = lfsr_ready delayed 1 cycle; edge = lfsr_ready & ~ready_q.
- IDLE/DONE + start:
  - capture seed into lfsr_seed;
  - clear resp_out, per-bit vote counters, word index, vote index and watchdog;
  - clear resp_valid and err;
  - set lfsr_load=1, busy=1;
  - go WAIT_RDY.
- WAIT_RDY:
  - watchdog increments each cycle.
  - On edge: clear watchdog and go to SETTLE if SETTLE>0, else SAMPLE.
  - On watchdog == TIMEOUT-1 without edge: set err=1, lfsr_load=0, go DONE.
- SETTLE: wait SETTLE cycles, then SAMPLE.
- SAMPLE:
  - each bit counter += puf_data[b] (counter width clog2(VOTES+1));
  - vote index++.
  - If votes remain: go SETTLE (or SAMPLE again if SETTLE=0) on the same challenge; no LFSR edge required.
  - Otherwise: word bit b = (count_b > VOTES/2); write the word to slot word_idx (bits [WIDTH-1-word_idx*WORD_W -: WORD_W]); clear counters and vote index.
  - Last word → DONE with lfsr_load=0, resp_valid=1. Otherwise word_idx++ and go ADVANCE.
- ADVANCE: lfsr_next=1 for exactly one cycle, then WAIT_RDY.
- DONE: busy=0. Hold resp_out, resp_valid and err until next accepted start.
- start while busy=1 is ignored. seed changes while busy are ignored.
- Total lfsr_next pulses per run = NUM_WORDS-1.

## Timing
- Reset values (cycle after rst sampled high): state IDLE; resp_out=0, resp_valid=0, err=0, busy=0, lfsr_load=0, lfsr_next=0, lfsr_seed=0; all counters 0.
- rst mid-run aborts immediately. No partial response is retained.
- start sampled at edge N → busy=1 and lfsr_load=1 from N+1.
- Per word:
  - edge detect: 1 cycle after lfsr_ready rises;
  - then VOTES×(SETTLE+1) cycles;
  - then 1 ADVANCE cycle.
- resp_valid rises in the cycle after the final SAMPLE. lfsr_load falls in the same cycle.
- A start in DONE clears resp_valid on the next cycle.
- err and resp_valid are never both 1.

## Test plan
- Defaults:
  - stimulus: model LFSR raises ready 2 cycles after load/next; PUF returns 16'hA000+k for challenge k; seed 16'hACE1.
  - required: resp_out = 128'hA000A001A002A003A004A005A006A007, resp_valid=1, err=0, exactly 7 lfsr_next pulses, lfsr_seed=16'hACE1.
- Majority vote:
  - stimulus: VOTES=3, NUM_WORDS=2; reads per challenge 16'h00FF, 16'h0F0F, 16'h3333.
  - required: each word = 16'h033F, resp_out = 32'h033F033F.
- Timeout:
  - stimulus: TIMEOUT=32, lfsr_ready held 0.
  - required: err=1 and busy=0 exactly 32 cycles after entering WAIT_RDY, resp_valid=0, lfsr_load=0.
- Handshake:
  - stimulus: start pulsed during word 3 with a new seed.
  - required: ignored, lfsr_seed unchanged, result identical to the undisturbed run.
  - stimulus: start pulsed in DONE.
  - required: resp_valid=0 and resp_out=0 on the next cycle, new run completes.
- Reset mid-run:
  - stimulus: rst asserted one cycle during word 4.
  - required: all outputs at reset values next cycle; no lfsr_next pulses until a new start.
- Settle:
  - stimulus: SETTLE=3, VOTES=1.
  - required: sample taken exactly 4 cycles after edge detect; PUF data changed during the settle cycles is not captured.
